// File: rtl/furv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : furv_pkg
// Brief    : RV32I opcodes, result-select encoding and the decoded control
//            bundle shared by decode_stage and imm_gen.
//            Optional macro: DECODE_ILLEGAL_EN adds the illegal flag.
// Revision : 1.0 - initial release
// ============================================================================
package furv_pkg;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;

  typedef enum logic [1:0] {
    ARITH = 2'd0,
    LOGIC = 2'd1,
    CMP   = 2'd2,
    LINK  = 2'd3
  } result_sel_t;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ra_use_pc;
    logic        rb_use_imm;
    logic        arith_mode;
    logic        logic_alt;
    logic [2:0]  funct3;
    logic        lt;
    logic        invert_comparison;
    logic        unsigned_comparison;
    result_sel_t result_sel;
    logic        reg_write;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
`ifdef DECODE_ILLEGAL_EN
    logic        illegal;
`endif
  } dec_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational RV32I immediate extraction (I/S/B/U/J), sign
//            extended to WIDTH bits; non-immediate opcodes yield zero.
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen
  import furv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr_i,
  output logic [WIDTH-1:0] imm_o
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (instr_i[6:0])
      JALR, LOAD, OP_IMM: w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      STORE:              w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      BRANCH:             w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                     instr_i[30:25], instr_i[11:8], 1'b0};
      LUI, AUIPC:         w_imm32 = {instr_i[31:12], 12'b0};
      JAL:                w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                     instr_i[20], instr_i[30:21], 1'b0};
      default:            w_imm32 = '0;
    endcase
  end

  generate
    if (WIDTH > 32) begin : g_sext
      assign imm_o = {{(WIDTH-32){w_imm32[31]}}, w_imm32};
    end else begin : g_fit
      assign imm_o = w_imm32[WIDTH-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Single-entry RV32I decode pipeline register between fetch and
//            execute, with flush. Optional macro: DECODE_ILLEGAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
  import furv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [WIDTH-1:0] imm,
  output logic             ra_use_pc,
  output logic             rb_use_imm,
  output logic             arith_mode,
  output logic             logic_alt,
  output logic [2:0]       funct3,
  output logic             lt,
  output logic             invert_comparison,
  output logic             unsigned_comparison,
  output logic [1:0]       result_sel,
  output logic             reg_write,
  output logic             is_branch,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             is_load,
`ifdef DECODE_ILLEGAL_EN
  output logic             illegal,
`endif
  output logic             is_store
);

  logic [6:0]       w_opcode;
  logic [2:0]       w_f3;
  logic             w_alu;
  logic             w_accept;
  logic             valid_d, valid_q;
  dec_ctrl_t        ctrl_d, ctrl_q;
  logic [WIDTH-1:0] imm_d, imm_q, pc_q;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_alu    = (w_opcode == OP) || (w_opcode == OP_IMM);

  imm_gen #(
    .WIDTH(WIDTH)
  ) u_imm_gen (
    .instr_i(in_instr),
    .imm_o  (imm_d)
  );

  // Pass-through readiness: a consumed entry frees the slot in the same cycle.
  assign in_ready = !valid_q || out_ready;
  assign w_accept = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q && !out_ready;
    if (w_accept) valid_d = 1'b1;
    if (flush)    valid_d = 1'b0;
  end

  always_comb begin
    ctrl_d     = '0;
    ctrl_d.rs1 = in_instr[19:15];
    ctrl_d.rs2 = in_instr[24:20];
    case (w_opcode)
      LUI: begin
        ctrl_d.rs1        = 5'd0;
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      AUIPC: begin
        ctrl_d.ra_use_pc  = 1'b1;
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.reg_write  = 1'b1;
      end
      JAL: begin
        ctrl_d.ra_use_pc  = 1'b1;
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.is_jal     = 1'b1;
        ctrl_d.result_sel = LINK;
      end
      JALR: begin
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.is_jalr    = 1'b1;
        ctrl_d.result_sel = LINK;
      end
      BRANCH: begin
        ctrl_d.is_branch           = 1'b1;
        ctrl_d.funct3              = w_f3;
        ctrl_d.lt                  = w_f3[2];
        ctrl_d.invert_comparison   = w_f3[0];
        ctrl_d.unsigned_comparison = w_f3[1];
      end
      LOAD: begin
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.is_load    = 1'b1;
      end
      STORE: begin
        ctrl_d.rb_use_imm = 1'b1;
        ctrl_d.is_store   = 1'b1;
      end
      OP, OP_IMM: begin
        ctrl_d.rb_use_imm = (w_opcode == OP_IMM);
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.funct3     = w_f3;
        ctrl_d.arith_mode = (w_opcode == OP) && (w_f3 == 3'b000) && in_instr[30];
        ctrl_d.logic_alt  = ((w_f3 == 3'b001) || (w_f3 == 3'b101)) && in_instr[30];
        case (w_f3)
          3'b000: ctrl_d.result_sel = ARITH;
          3'b010, 3'b011: begin
            // SLT/SLTU: funct3 bit 2 is clear, so lt is set explicitly.
            ctrl_d.result_sel          = CMP;
            ctrl_d.lt                  = 1'b1;
            ctrl_d.unsigned_comparison = w_f3[0];
          end
          default: ctrl_d.result_sel = LOGIC;
        endcase
`ifdef DECODE_ILLEGAL_EN
        if (w_opcode == OP)
          ctrl_d.illegal = (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20);
        else if (w_f3 == 3'b001)
          ctrl_d.illegal = (in_instr[31:25] != 7'h00);
        else if (w_f3 == 3'b101)
          ctrl_d.illegal = (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20);
`endif
      end
      default: begin
`ifdef DECODE_ILLEGAL_EN
        ctrl_d.illegal = 1'b1;
`endif
      end
    endcase
`ifdef DECODE_ILLEGAL_EN
    if (ctrl_d.illegal) begin
      ctrl_d.reg_write = 1'b0;
      ctrl_d.is_branch = 1'b0;
      ctrl_d.is_jal    = 1'b0;
      ctrl_d.is_jalr   = 1'b0;
      ctrl_d.is_load   = 1'b0;
      ctrl_d.is_store  = 1'b0;
    end
`endif
    ctrl_d.rd = ctrl_d.reg_write ? in_instr[11:7] : 5'd0;
  end

  // Fields only load on accept, so a held entry stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      if (w_accept) begin
        ctrl_q <= ctrl_d;
        imm_q  <= imm_d;
        pc_q   <= in_pc;
      end
    end
  end

  assign out_valid           = valid_q;
  assign out_pc              = pc_q;
  assign imm                 = imm_q;
  assign rs1                 = ctrl_q.rs1;
  assign rs2                 = ctrl_q.rs2;
  assign rd                  = ctrl_q.rd;
  assign ra_use_pc           = ctrl_q.ra_use_pc;
  assign rb_use_imm          = ctrl_q.rb_use_imm;
  assign arith_mode          = ctrl_q.arith_mode;
  assign logic_alt           = ctrl_q.logic_alt;
  assign funct3              = ctrl_q.funct3;
  assign lt                  = ctrl_q.lt;
  assign invert_comparison   = ctrl_q.invert_comparison;
  assign unsigned_comparison = ctrl_q.unsigned_comparison;
  assign result_sel          = ctrl_q.result_sel;
  assign reg_write           = ctrl_q.reg_write;
  assign is_branch           = ctrl_q.is_branch;
  assign is_jal              = ctrl_q.is_jal;
  assign is_jalr             = ctrl_q.is_jalr;
  assign is_load             = ctrl_q.is_load;
  assign is_store            = ctrl_q.is_store;
`ifdef DECODE_ILLEGAL_EN
  assign illegal             = ctrl_q.illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Directed and randomized bench for decode_stage against an
//            instruction-level reference model. Honours DECODE_ILLEGAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rs1, rs2, rd;
  logic        ra_use_pc, rb_use_imm, arith_mode, logic_alt;
  logic [2:0]  funct3;
  logic        lt, invert_comparison, unsigned_comparison;
  logic [1:0]  result_sel;
  logic        reg_write, is_branch, is_jal, is_jalr, is_load, is_store;
`ifdef DECODE_ILLEGAL_EN
  logic        illegal;
`endif

  decode_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .ra_use_pc(ra_use_pc), .rb_use_imm(rb_use_imm),
    .arith_mode(arith_mode), .logic_alt(logic_alt), .funct3(funct3),
    .lt(lt), .invert_comparison(invert_comparison),
    .unsigned_comparison(unsigned_comparison), .result_sel(result_sel),
    .reg_write(reg_write), .is_branch(is_branch), .is_jal(is_jal),
    .is_jalr(is_jalr), .is_load(is_load),
`ifdef DECODE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .is_store(is_store)
  );

  int total = 0, passed = 0, failed = 0;
  logic         m_valid;
  logic [127:0] m_vec;
  logic [127:0] dut_vec;

  assign dut_vec = 128'({out_pc, rs1, rs2, rd, imm, ra_use_pc, rb_use_imm, arith_mode,
                         logic_alt, funct3, lt, invert_comparison, unsigned_comparison,
                         result_sel, reg_write, is_branch, is_jal, is_jalr, is_load, is_store
`ifdef DECODE_ILLEGAL_EN
                         , illegal
`endif
                         });

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: classify the opcode, then derive every field.
  function automatic logic [127:0] model(input logic [31:0] ins, input logic [31:0] pc);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    bit          lui, auipc, jal, jalr, br, ld, st, opi, opr, alu, ill, rw;
    bit          e_lt, e_inv, e_uns;
    logic [1:0]  sel;
    int          v;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    lui = (op == 7'h37); auipc = (op == 7'h17); jal = (op == 7'h6F); jalr = (op == 7'h67);
    br = (op == 7'h63); ld = (op == 7'h03); st = (op == 7'h23);
    opi = (op == 7'h13); opr = (op == 7'h33);
    alu = opi || opr;
    ill = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    ill = !(lui || auipc || jal || jalr || br || ld || st || opi || opr)
          || (opr && f7 != 7'h00 && f7 != 7'h20)
          || (opi && f3 == 3'd1 && f7 != 7'h00)
          || (opi && f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
`endif
    v = 0;
    if (jalr || ld || opi) begin
      v = int'(ins[31:20]); if (v >= 2048) v -= 4096;
    end else if (st) begin
      v = int'({ins[31:25], ins[11:7]}); if (v >= 2048) v -= 4096;
    end else if (br) begin
      v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end else if (lui || auipc) begin
      v = int'(ins[31:12]) * 4096;
    end else if (jal) begin
      v = int'(ins[31]) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
          + int'(ins[30:21]) * 2;
      if (v >= 1048576) v -= 2097152;
    end
    if (jal || jalr)                         sel = 2'd3;
    else if (alu && (f3 == 3'd2 || f3 == 3'd3)) sel = 2'd2;
    else if (alu && f3 != 3'd0)              sel = 2'd1;
    else                                     sel = 2'd0;
    e_lt = 1'b0; e_inv = 1'b0; e_uns = 1'b0;
    if (br) begin
      e_lt = f3[2]; e_inv = f3[0]; e_uns = f3[1];
    end else if (alu && (f3 == 3'd2 || f3 == 3'd3)) begin
      e_lt = 1'b1; e_uns = (f3 == 3'd3);
    end
    rw = (lui || auipc || jal || jalr || ld || opr || opi) && !ill;
    return 128'({pc, lui ? 5'd0 : ins[19:15], ins[24:20], rw ? ins[11:7] : 5'd0, 32'(v),
                 (auipc || jal), (lui || auipc || jal || jalr || ld || st || opi),
                 (opr && f3 == 3'd0 && ins[30]), (alu && (f3 == 3'd1 || f3 == 3'd5) && ins[30]),
                 (alu || br) ? f3 : 3'd0, e_lt, e_inv, e_uns, sel, rw,
                 br && !ill, jal && !ill, jalr && !ill, ld && !ill, st && !ill
`ifdef DECODE_ILLEGAL_EN
                 , ill
`endif
                 });
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    r = $urandom();
    k = $urandom_range(0, 10);
    r[6:0] = ops[k];
    if ((r[6:0] == 7'h33 || (r[6:0] == 7'h13 && (r[14:12] == 3'd1 || r[14:12] == 3'd5)))
        && $urandom_range(0, 3) != 0)
      r[31:25] = r[30] ? 7'h20 : 7'h00;
    return r;
  endfunction

  // Drive one cycle of inputs, check in_ready, then check outputs after the edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic acc;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    check("in_ready", 128'(in_ready), 128'(!m_valid || ordy));
    acc = v && (!m_valid || ordy) && !fl;
    @(posedge clk); #1;
    if (fl)          m_valid = 1'b0;
    else if (acc)    begin m_valid = 1'b1; m_vec = model(ins, pc); end
    else if (ordy)   m_valid = 1'b0;
    check("out_valid", 128'(out_valid), 128'(m_valid));
    if (m_valid) check("fields", dut_vec, m_vec);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    m_valid = 1'b0; m_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 128'(out_valid), 128'(0));
    check("reset_fields", dut_vec, 128'(0));
    rst = 1'b0;

    // SUB x3,x1,x2
    cycle(1'b1, 32'h402081B3, 32'h0000_1000, 1'b1, 1'b0);
    check("sub_arith", 128'(arith_mode), 128'(1));
    check("sub_rd", 128'(rd), 128'(3));
    check("sub_sel", 128'(result_sel), 128'(0));
    // BGEU x1,x2,-4
    cycle(1'b1, 32'hFE20FEE3, 32'h0000_1004, 1'b1, 1'b0);
    check("bgeu_imm", 128'(imm), 128'(32'hFFFFFFFC));
    check("bgeu_cmp", 128'({lt, invert_comparison, unsigned_comparison}), 128'(3'b111));
    check("bgeu_rd", 128'(rd), 128'(0));
    // ADDI then SRAI back-to-back
    cycle(1'b1, 32'hFFF00293, 32'h0000_1008, 1'b1, 1'b0);
    check("addi_imm", 128'(imm), 128'(32'hFFFFFFFF));
    check("addi_rbimm", 128'(rb_use_imm), 128'(1));
    cycle(1'b1, 32'h4030D093, 32'h0000_100C, 1'b1, 1'b0);
    check("srai_alt", 128'(logic_alt), 128'(1));
    check("srai_f3", 128'(funct3), 128'(5));
    check("srai_sel", 128'(result_sel), 128'(1));
    check("srai_shamt", 128'(imm[4:0]), 128'(3));

    // Backpressure: three stalled cycles, then release accepts in the same cycle.
    repeat (3) cycle(1'b1, 32'h00A00513, 32'h0000_2000, 1'b0, 1'b0);
    cycle(1'b1, 32'h00A00513, 32'h0000_2000, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with a held entry and a valid input, then flush alongside out_ready.
    cycle(1'b1, 32'h0000006F, 32'h0000_3000, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 32'h00112623, 32'h0000_3004, 1'b1, 1'b0);
    cycle(1'b1, 32'h00008067, 32'h0000_3008, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset while holding an entry.
    cycle(1'b1, 32'h123452B7, 32'h0000_4000, 1'b1, 1'b0);
    cycle(1'b1, 32'h00000317, 32'h0000_4004, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    check("rst_hold_valid", 128'(out_valid), 128'(0));
    check("rst_hold_fields", dut_vec, 128'(0));
    rst = 1'b0;

    // All-zero word.
    cycle(1'b1, 32'h00000000, 32'h0000_5000, 1'b1, 1'b0);
    check("zero_rw", 128'(reg_write), 128'(0));
`ifdef DECODE_ILLEGAL_EN
    check("zero_illegal", 128'(illegal), 128'(1));
`else
    check("zero_valid", 128'(out_valid), 128'(1));
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      pc = $urandom() & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 3) != 0), rand_instr(), pc,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
